// File: rtl/reg_file_8x8.sv
// Operand register file: two combinational read ports, one clocked write port.
// Optional same-cycle write forwarding and optional hardwired-zero register 0.
module reg_file_8x8 #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 3,
    parameter bit          BYPASS     = 1'b0,
    parameter bit          ZERO_REG   = 1'b0
) (
    input  logic                  CLK,
    input  logic                  RESETN,
    input  logic                  WRITEENABLE,
    input  logic [ADDR_WIDTH-1:0] WRITEREG,
    input  logic [DATA_WIDTH-1:0] WRITEDATA,
    input  logic [ADDR_WIDTH-1:0] READREG1,
    input  logic [ADDR_WIDTH-1:0] READREG2,
    output logic [DATA_WIDTH-1:0] REGOUT1,
    output logic [DATA_WIDTH-1:0] REGOUT2
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] r_regs [DEPTH];

    logic w_wr_is_zero;
    logic w_wr_commit;
    logic w_rd1_is_zero;
    logic w_rd2_is_zero;
    logic w_fwd1;
    logic w_fwd2;

    always_comb begin
        w_wr_is_zero  = ZERO_REG && (WRITEREG == '0);
        w_rd1_is_zero = ZERO_REG && (READREG1 == '0);
        w_rd2_is_zero = ZERO_REG && (READREG2 == '0);
        w_wr_commit   = WRITEENABLE && !w_wr_is_zero;
        // Forwarding mirrors the commit condition so a port never shows a value that won't land.
        w_fwd1        = BYPASS && RESETN && w_wr_commit && (READREG1 == WRITEREG);
        w_fwd2        = BYPASS && RESETN && w_wr_commit && (READREG2 == WRITEREG);
    end

    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wr_commit) begin
            r_regs[WRITEREG] <= WRITEDATA;
        end
    end

    always_comb begin
        REGOUT1 = r_regs[READREG1];
        if (w_rd1_is_zero) begin
            REGOUT1 = '0;
        end else if (w_fwd1) begin
            REGOUT1 = WRITEDATA;
        end
    end

    always_comb begin
        REGOUT2 = r_regs[READREG2];
        if (w_rd2_is_zero) begin
            REGOUT2 = '0;
        end else if (w_fwd2) begin
            REGOUT2 = WRITEDATA;
        end
    end

endmodule

// File: doc/reg_file_8x8.md
Name: reg_file_8x8

Overview:
- Operand register file for the 8-bit single-cycle processor.
- Supplies the two signed 8-bit operands (A, B) to the ALU function units (AND, OR, ADD, MOV) through two read ports.
- Accepts the ALU result (C) back through one clocked write port.
- Reads are combinational so that a full read-execute-writeback completes in one processor cycle.
- Writes commit on the rising clock edge.

Parameters:
- DATA_WIDTH, 8, bit width of each register and of every data port.
- ADDR_WIDTH, 3, register address width; DEPTH = 2**ADDR_WIDTH (8 registers).
- BYPASS, 0, when 1 a same-cycle write is forwarded to a read port addressing the write target.
- ZERO_REG, 0, when 1 register 0 is hardwired to zero and writes to it are discarded.

Ports:
- CLK  input  1  system clock; all state changes occur on its rising edge.
- RESETN  input  1  synchronous active-low reset, sampled on rising CLK.
- WRITEENABLE  input  1  commit WRITEDATA to WRITEREG at the next rising edge.
- WRITEREG  input  ADDR_WIDTH  destination register address.
- WRITEDATA  input  DATA_WIDTH  result to store (ALU output C).
- READREG1  input  ADDR_WIDTH  source address for operand 1.
- READREG2  input  ADDR_WIDTH  source address for operand 2.
- REGOUT1  output  DATA_WIDTH  contents of READREG1 (ALU operand A).
- REGOUT2  output  DATA_WIDTH  contents of READREG2 (ALU operand B).

Behaviour:
- Storage: DEPTH x DATA_WIDTH registers.
  - Data is stored as raw bits; two's-complement interpretation belongs to the consumer.
  - No sign or zero extension is performed.
- Reset:
  - RESETN low at a rising CLK edge clears all registers to 0 at that edge.
  - Reset has priority over a simultaneous write; the write is dropped.
  - Reset asserted mid-sequence discards every prior write.
  - Before the first reset edge, register contents are X and are not checked.
- Outputs after reset: REGOUT1 = REGOUT2 = 0 for any address, until a write commits.
- Write:
  - Commits when RESETN = 1 and WRITEENABLE = 1 at a rising CLK edge: reg[WRITEREG] <= WRITEDATA.
  - Latency is 1 edge; the new value is visible on the read ports in the same delta after the edge.
  - WRITEENABLE = 0 leaves all registers unchanged regardless of WRITEREG and WRITEDATA.
- Read:
  - Purely combinational: REGOUTn = reg[READREGn].
  - Address changes propagate with no clock involvement.
  - Both ports may address the same register and must return identical values.
- Same-cycle read and write to the same address:
  - BYPASS = 0: the read port shows the old value until the edge, then the new value.
  - BYPASS = 1: when WRITEENABLE = 1, RESETN = 1 and READREGn == WRITEREG, REGOUTn = WRITEDATA before the edge.
- ZERO_REG = 1:
  - Reads of address 0 return 0.
  - Writes to address 0 are ignored.
  - Bypass never forwards to address 0.
- Address range: all ADDR_WIDTH-bit addresses are valid; no out-of-range case exists.
- X/Z on WRITEENABLE at an edge is a bench error; the RTL need not define the result.

Test Plan:
- Reset clear: hold RESETN = 0 for 1 edge, sweep READREG1/2 over 0..7 -> REGOUT1 = REGOUT2 = 0 at every address.
- Write then read: write 8'hD4 to r2 and 8'h0A to r5; set READREG1 = 2, READREG2 = 5 -> REGOUT1 = 8'hD4 (-44 signed), REGOUT2 = 8'h0A. Driving these into the AND unit gives C = 8'h00.
- Write-enable gating: WRITEENABLE = 0, WRITEREG = 3, WRITEDATA = 8'hFF over 3 edges -> r3 stays at its prior value (0 after reset).
- Same-address collision: r4 = 15; in one cycle write 11 to r4 with READREG1 = 4.
  - BYPASS = 0: REGOUT1 = 15 before the edge, 11 after.
  - BYPASS = 1: REGOUT1 = 11 before the edge.
- Reset priority: RESETN = 0 and WRITEENABLE = 1 (r1 <= 8'h55) on the same edge -> r1 = 0; all other registers = 0.
- Full sweep and ZERO_REG:
  - Write value 8'h10+i to ri for i = 0..7 -> readback of all pairs matches.
  - With ZERO_REG = 1, r0 reads 0 after writing 8'h10.
